// File: rtl/mul_pkg.sv
// Shared types and helpers for the shift-add multiplier.
// State encoding and counter sizing live here.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// N-bit ripple-carry adder that exports its final carry.
// Bit 0 has no carry-in, so it degenerates to a half adder.
module ripple_adder_co #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] cy;

  assign cy[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    logic p;
    logic g;
    assign p         = a[i] ^ b[i];
    assign g         = a[i] & b[i];
    assign sum[i]    = p ^ cy[i];
    assign cy[i+1]   = g | (p & cy[i]);
  end

  assign cout = cy[N];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N multiplier, one partial product per cycle.
// Operands and product move over valid/ready handshakes.
module shift_add_multiplier
  import mul_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] product
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state;
  state_t state_n;

  logic [N-1:0]   hi;
  logic [N-1:0]   lo;
  logic [N-1:0]   m;
  logic [CW-1:0]  count;
  logic [2*N-1:0] prod_q;

  logic [N-1:0]   addend;
  logic [N-1:0]   s;
  logic           c;
  logic           take;

  assign addend  = lo[0] ? m : '0;
  assign take    = in_valid && in_ready;
  assign product = prod_q;

  ripple_adder_co #(
    .N (N)
  ) u_add (
    .a    (hi),
    .b    (addend),
    .sum  (s),
    .cout (c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) state_n = RUN;
      end
      RUN: begin
        if (count == LAST) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Carry-out lands in hi's MSB so no product bit is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      m      <= '0;
      count  <= '0;
      prod_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            m     <= a;
            hi    <= '0;
            lo    <= b;
            count <= '0;
          end
        end
        RUN: begin
          hi    <= {c, s[N-1:1]};
          lo    <= {s[0], lo[N-1:1]};
          count <= count + 1'b1;
          if (count == LAST) prod_q <= {c, s, lo[N-1:1]};
        end
        default: ;
      endcase
    end
  end

endmodule
